// File: rtl/traffic_signal_controller.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_signal_controller
//  Description : Moore FSM controlling a highway / country-road crossing.
//                The highway is green by default. A car on the country road
//                starts a timed hand-over (yellow, then all-red, then country
//                green). The country road keeps green while cars are present,
//                then goes yellow and returns right-of-way to the highway.
//  Ports       : CLOCK               - system clock, rising edge active
//                CLEAR               - asynchronous active-low reset
//                CAR_ON_COUNTRY_ROAD - 1 = vehicle present on country road
//                MAIN_SIG            - highway lamp code (0 RED/1 YEL/2 GRN)
//                COUNTRY_SIG         - country lamp code (same encoding)
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_signal_controller #(
    parameter int unsigned Y2RDELAY = 3,   // yellow dwell, 1..15 cycles
    parameter int unsigned R2GDELAY = 2    // all-red dwell, 1..15 cycles
) (
    output logic [1:0] MAIN_SIG,
    output logic [1:0] COUNTRY_SIG,
    input  logic       CAR_ON_COUNTRY_ROAD,
    input  logic       CLOCK,
    input  logic       CLEAR
);

    // Lamp codes
    localparam logic [1:0] C_RED    = 2'd0;
    localparam logic [1:0] C_YELLOW = 2'd1;
    localparam logic [1:0] C_GREEN  = 2'd2;

    // The dwell counter counts down to zero, so it is loaded with delay-1
    localparam logic [3:0] C_Y2R_LOAD = 4'(Y2RDELAY - 1);
    localparam logic [3:0] C_R2G_LOAD = 4'(R2GDELAY - 1);

    typedef enum logic [2:0] {
        S0 = 3'd0,   // main green, country red
        S1 = 3'd1,   // main yellow, country red
        S2 = 3'd2,   // all red
        S3 = 3'd3,   // main red, country green
        S4 = 3'd4    // main red, country yellow
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // State and dwell-counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            state_q <= S0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S0: begin
                if (CAR_ON_COUNTRY_ROAD) begin
                    state_d = S1;
                    cnt_d   = C_Y2R_LOAD;
                end
            end
            S1: begin
                if (cnt_q == 4'd0) begin
                    state_d = S2;
                    cnt_d   = C_R2G_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S2: begin
                if (cnt_q == 4'd0) begin
                    state_d = S3;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S3: begin
                if (!CAR_ON_COUNTRY_ROAD) begin
                    state_d = S4;
                    cnt_d   = C_Y2R_LOAD;
                end
            end
            S4: begin
                if (cnt_q == 4'd0) begin
                    state_d = S0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                // Unreachable encodings recover to the safe default state
                state_d = S0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode; any unknown state shows highway green only
    // ------------------------------------------------------------------
    always_comb begin
        MAIN_SIG    = C_GREEN;
        COUNTRY_SIG = C_RED;
        case (state_q)
            S0: begin
                MAIN_SIG    = C_GREEN;
                COUNTRY_SIG = C_RED;
            end
            S1: begin
                MAIN_SIG    = C_YELLOW;
                COUNTRY_SIG = C_RED;
            end
            S2: begin
                MAIN_SIG    = C_RED;
                COUNTRY_SIG = C_RED;
            end
            S3: begin
                MAIN_SIG    = C_RED;
                COUNTRY_SIG = C_GREEN;
            end
            S4: begin
                MAIN_SIG    = C_RED;
                COUNTRY_SIG = C_YELLOW;
            end
            default: begin
                MAIN_SIG    = C_GREEN;
                COUNTRY_SIG = C_RED;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_signal_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_signal_controller
//  Description : Directed self-checking bench. Instance A uses the default
//                delays (3/2); instance B uses Y2RDELAY=1, R2GDELAY=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_signal_controller;

    logic       clk;
    logic       clear_n;
    logic       car_a, car_b;
    logic [1:0] main_a, country_a, main_b, country_b;

    int n_cmp  = 0;
    int n_fail = 0;

    traffic_signal_controller dut_a (
        .MAIN_SIG            (main_a),
        .COUNTRY_SIG         (country_a),
        .CAR_ON_COUNTRY_ROAD (car_a),
        .CLOCK               (clk),
        .CLEAR               (clear_n)
    );

    traffic_signal_controller #(
        .Y2RDELAY (1),
        .R2GDELAY (4)
    ) dut_b (
        .MAIN_SIG            (main_b),
        .COUNTRY_SIG         (country_b),
        .CAR_ON_COUNTRY_ROAD (car_b),
        .CLOCK               (clk),
        .CLEAR               (clear_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected lamp codes for state numbers 0..4
    function automatic logic [1:0] exp_main(input int s);
        case (s)
            0:       return 2'd2;
            1:       return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] exp_country(input int s);
        case (s)
            3:       return 2'd2;
            4:       return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_both(input string tag, input int sa, input int sb);
        chk({tag, ".A.main"},    main_a,    exp_main(sa));
        chk({tag, ".A.country"}, country_a, exp_country(sa));
        chk({tag, ".B.main"},    main_b,    exp_main(sb));
        chk({tag, ".B.country"}, country_b, exp_country(sb));
        // Conflict check: never both roads non-red at once
        n_cmp++;
        assert (!((main_a != 2'd0) && (country_a != 2'd0)) &&
                !((main_b != 2'd0) && (country_b != 2'd0))) else begin
            n_fail++;
            $error("FAIL %s.conflict observed=A:%0d/%0d B:%0d/%0d expected=one road red",
                   tag, main_a, country_a, main_b, country_b);
        end
    endtask

    // Apply car inputs, take n rising edges, check the state after each one
    task automatic run(input string tag, input logic ca, input logic cb,
                       input int n, input int sa, input int sb);
        for (int i = 0; i < n; i++) begin
            car_a = ca;
            car_b = cb;
            @(posedge clk);
            #1;
            chk_both(tag, sa, sb);
        end
    endtask

    initial begin
        clear_n = 1'b0;
        car_a   = 1'b0;
        car_b   = 1'b0;

        // 1. Reset held, then idle with no car
        run("reset_hold", 1'b0, 1'b0, 5, 0, 0);
        @(negedge clk);
        clear_n = 1'b1;
        run("idle", 1'b0, 1'b0, 20, 0, 0);

        // 2. Car present for 10 sampled edges
        run("seq_s1", 1'b1, 1'b0, 3, 1, 0);
        run("seq_s2", 1'b1, 1'b0, 2, 2, 0);
        run("seq_s3", 1'b1, 1'b0, 5, 3, 0);
        run("seq_s4", 1'b0, 1'b0, 3, 4, 0);
        run("seq_s0", 1'b0, 1'b0, 3, 0, 0);

        // 3. Single-cycle car pulse: full sequence, S3 lasts one cycle
        run("pulse_s1a", 1'b1, 1'b0, 1, 1, 0);
        run("pulse_s1b", 1'b0, 1'b0, 2, 1, 0);
        run("pulse_s2",  1'b0, 1'b0, 2, 2, 0);
        run("pulse_s3",  1'b0, 1'b0, 1, 3, 0);
        run("pulse_s4",  1'b0, 1'b0, 3, 4, 0);
        run("pulse_s0",  1'b0, 1'b0, 2, 0, 0);

        // 4. Car returns early; car still present on return to S0
        run("cont_s1",  1'b1, 1'b0, 3, 1, 0);
        run("cont_s2",  1'b1, 1'b0, 2, 2, 0);
        run("cont_s3",  1'b1, 1'b0, 1, 3, 0);
        run("cont_s4a", 1'b0, 1'b0, 1, 4, 0);
        run("cont_s4b", 1'b1, 1'b0, 2, 4, 0);
        run("cont_s0",  1'b1, 1'b0, 1, 0, 0);
        run("cont_s1b", 1'b1, 1'b0, 3, 1, 0);
        run("cont_s2b", 1'b1, 1'b0, 2, 2, 0);
        run("cont_s3b", 1'b1, 1'b0, 3, 3, 0);

        // 5. Asynchronous reset while in S3, between edges
        clear_n = 1'b0;
        #2;
        chk_both("async_reset", 0, 0);
        @(negedge clk);
        clear_n = 1'b1;
        run("post_reset", 1'b0, 1'b0, 4, 0, 0);
        run("post_s1", 1'b1, 1'b0, 1, 1, 0);
        run("post_s1b", 1'b0, 1'b0, 2, 1, 0);
        run("post_s2", 1'b0, 1'b0, 2, 2, 0);
        run("post_s3", 1'b0, 1'b0, 1, 3, 0);
        run("post_s4", 1'b0, 1'b0, 3, 4, 0);
        run("post_s0", 1'b0, 1'b0, 1, 0, 0);

        // 6. Instance B: 1-cycle yellows, 4-cycle all-red, 6-edge latency
        run("ovr_s1", 1'b0, 1'b1, 1, 0, 1);
        run("ovr_s2", 1'b0, 1'b1, 4, 0, 2);
        run("ovr_s3", 1'b0, 1'b1, 1, 0, 3);
        run("ovr_s4", 1'b0, 1'b0, 1, 0, 4);
        run("ovr_s0", 1'b0, 1'b0, 2, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
